// File: rtl/dpu_issue.sv
// Instruction issuer for the DPU: FIFO-buffers instructions, drives them onto the
// operand bus for SETTLE cycles, then captures k/cc and hands them downstream.
module dpu_issue #(
  parameter int DEPTH  = 8,
  parameter int SETTLE = 1,
  parameter int CW     = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [14:0]   instr_in,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic          flush,
  output logic [3:0]    Abus,
  output logic [3:0]    Bbus,
  output logic [3:0]    Rbus,
  output logic [2:0]    n,
  input  logic [23:0]   k_in,
  input  logic [3:0]    cc_in,
  output logic [23:0]   res_k,
  output logic [3:0]    res_cc,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [CW-1:0] count,
  output logic          busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {IDLE, WAIT, OUT} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [14:0]     mem_q [DEPTH];
  logic [14:0]     ops_q;
  logic [23:0]     res_k_q;
  logic [3:0]      res_cc_q;
  logic            full, empty, push, pop, capture;

  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign instr_ready = !full && !flush;
  assign push        = instr_valid && instr_ready;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    pop      = 1'b0;
    capture  = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            pop      = 1'b1;
            settle_d = SW'(SETTLE);
            state_d  = WAIT;
          end
        end
        WAIT: begin
          if (settle_q == SW'(1)) begin
            capture = 1'b1;
            state_d = OUT;
          end else begin
            settle_d = settle_q - SW'(1);
          end
        end
        OUT: begin
          // Chain straight into the next instruction on the handshake edge.
          if (res_ready) begin
            if (!empty) begin
              pop      = 1'b1;
              settle_d = SW'(SETTLE);
              state_d  = WAIT;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= instr_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      settle_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ops_q    <= '0;
      res_k_q  <= '0;
      res_cc_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        case ({push, pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
      // Operands stay on the bus after a flush or when returning to IDLE.
      if (pop) ops_q <= mem_q[rd_ptr_q];
      if (capture) begin
        res_k_q  <= k_in;
        res_cc_q <= cc_in;
      end
    end
  end

  assign Abus      = ops_q[3:0];
  assign Bbus      = ops_q[7:4];
  assign Rbus      = ops_q[11:8];
  assign n         = ops_q[14:12];
  assign res_k     = res_k_q;
  assign res_cc    = res_cc_q;
  assign res_valid = (state_q == OUT);
  assign count     = count_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dpu_issue.sv
// Directed bench for dpu_issue; a behavioural DPU model supplies k/cc from the operand bus.
module tb_dpu_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [14:0] instr_in = '0;
  logic        instr_valid = 1'b0;
  logic        flush = 1'b0;
  logic        res_ready = 1'b0;

  logic        ir1, rv1, busy1, ir3, rv3, busy3;
  logic [3:0]  a1, b1, r1, cc1, rcc1, a3, b3, r3, cc3, rcc3;
  logic [2:0]  n1, n3;
  logic [23:0] k1, rk1, k3, rk3;
  logic [3:0]  cnt1, cnt3;
  logic [14:0] ops1, ops3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [23:0] kf(input logic [14:0] x);
    return {x[7:0], x, 1'b1} ^ 24'h5A3C96;
  endfunction

  function automatic logic [3:0] ccf(input logic [14:0] x);
    return x[3:0] ^ x[7:4] ^ {1'b0, x[14:12]};
  endfunction

  assign ops1 = {n1, r1, b1, a1};
  assign ops3 = {n3, r3, b3, a3};
  assign k1   = kf(ops1);
  assign cc1  = ccf(ops1);
  assign k3   = kf(ops3);
  assign cc3  = ccf(ops3);

  dpu_issue #(.DEPTH(8), .SETTLE(1)) u_dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(ir1), .flush(flush), .Abus(a1), .Bbus(b1), .Rbus(r1), .n(n1),
    .k_in(k1), .cc_in(cc1), .res_k(rk1), .res_cc(rcc1), .res_valid(rv1),
    .res_ready(res_ready), .count(cnt1), .busy(busy1)
  );

  dpu_issue #(.DEPTH(8), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(ir3), .flush(flush), .Abus(a3), .Bbus(b3), .Rbus(r3), .n(n3),
    .k_in(k3), .cc_in(cc3), .res_k(rk3), .res_cc(rcc3), .res_valid(rv3),
    .res_ready(res_ready), .count(cnt3), .busy(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [14:0] t [10];
  logic [14:0] u [5];
  logic [14:0] i0, i1, i2, g;
  int idx, got;
  logic acc;

  initial begin
    // Reset asserted mid-cycle, before any clock edge
    #3 rst = 1'b1;
    #1;
    chk("rst_res_valid", 32'(rv1), 32'd0);
    chk("rst_ops", 32'(ops1), 32'd0);
    chk("rst_count", 32'(cnt1), 32'd0);
    chk("rst_res_k", 32'(rk1), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_instr_ready", 32'(ir1), 32'd1);
    chk("rel_busy", 32'(busy1), 32'd0);
    tick();

    // Single issue
    res_ready = 1'b1;
    instr_in = 15'h098B; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("single_e0_count", 32'(cnt1), 32'd1);
    chk("single_e0_busy", 32'(busy1), 32'd0);
    tick();
    chk("single_e1_ops", 32'(ops1), 32'h098B);
    chk("single_e1_valid", 32'(rv1), 32'd0);
    chk("single_e1_count", 32'(cnt1), 32'd0);
    tick();
    chk("single_e2_valid", 32'(rv1), 32'd1);
    chk("single_e2_k", 32'(rk1), 32'(kf(15'h098B)));
    chk("single_e2_cc", 32'(rcc1), 32'(ccf(15'h098B)));
    $display("single issue: instr=%h res_k=%h res_cc=%h", 15'h098B, rk1, rcc1);
    tick();
    chk("single_e3_busy", 32'(busy1), 32'd0);
    chk("single_e3_valid", 32'(rv1), 32'd0);

    // Back-to-back ordering
    i0 = 15'h098B; i1 = 15'h4AA3; i2 = 15'h4B00;
    instr_valid = 1'b1;
    instr_in = i0; tick();
    instr_in = i1; tick();
    instr_in = i2; tick();
    instr_valid = 1'b0;
    chk("b2b_r0_valid", 32'(rv1), 32'd1);
    chk("b2b_r0_k", 32'(rk1), 32'(kf(i0)));
    tick();
    chk("b2b_gap0_valid", 32'(rv1), 32'd0);
    chk("b2b_gap0_busy", 32'(busy1), 32'd1);
    chk("b2b_gap0_ops", 32'(ops1), 32'(i1));
    tick();
    chk("b2b_r1_valid", 32'(rv1), 32'd1);
    chk("b2b_r1_k", 32'(rk1), 32'(kf(i1)));
    tick();
    chk("b2b_gap1_busy", 32'(busy1), 32'd1);
    tick();
    chk("b2b_r2_valid", 32'(rv1), 32'd1);
    chk("b2b_r2_k", 32'(rk1), 32'(kf(i2)));
    chk("b2b_r2_cc", 32'(rcc1), 32'(ccf(i2)));
    tick();
    chk("b2b_end_busy", 32'(busy1), 32'd0);
    chk("b2b_end_count", 32'(cnt1), 32'd0);

    // Backpressure and full
    for (int i = 0; i < 10; i++) t[i] = {3'(i), 4'(i + 1), 4'(i ^ 5), 4'(15 - i)};
    res_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 14; c++) begin
      instr_in = t[idx]; instr_valid = 1'b1; acc = ir1;
      tick();
      if (acc) idx++;
    end
    instr_in = t[idx];
    chk("full_accepted", 32'(idx), 32'd9);
    chk("full_count", 32'(cnt1), 32'd8);
    chk("full_instr_ready", 32'(ir1), 32'd0);
    chk("full_res_valid", 32'(rv1), 32'd1);
    chk("full_res_k_stable", 32'(rk1), 32'(kf(t[0])));
    chk("full_ops", 32'(ops1), 32'(t[0]));
    res_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 60 && got < 10; c++) begin
      if (idx < 10) begin
        instr_in = t[idx]; instr_valid = 1'b1; acc = ir1;
      end else begin
        instr_valid = 1'b0; acc = 1'b0;
      end
      if (rv1) begin
        chk("drain_k", 32'(rk1), 32'(kf(t[got])));
        $display("drain result %0d: res_k=%h res_cc=%h", got, rk1, rcc1);
        got++;
      end
      tick();
      if (acc) idx++;
    end
    instr_valid = 1'b0;
    chk("drain_results", 32'(got), 32'd10);
    chk("drain_pushed", 32'(idx), 32'd10);
    chk("drain_count", 32'(cnt1), 32'd0);
    chk("drain_busy", 32'(busy1), 32'd0);

    // Simultaneous push/pop with count=3 in OUT
    u[0] = 15'h1111; u[1] = 15'h2222; u[2] = 15'h3333; u[3] = 15'h4444; u[4] = 15'h5555;
    res_ready = 1'b0;
    instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      instr_in = u[i];
      tick();
    end
    chk("sim_pre_count", 32'(cnt1), 32'd3);
    chk("sim_pre_valid", 32'(rv1), 32'd1);
    instr_in = u[4]; res_ready = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("sim_count", 32'(cnt1), 32'd3);
    chk("sim_ops", 32'(ops1), 32'(u[1]));
    chk("sim_valid", 32'(rv1), 32'd0);

    // Flush mid-WAIT on the SETTLE=3 instance
    rst = 1'b1;
    tick();
    rst = 1'b0;
    instr_valid = 1'b1; instr_in = 15'h0123;
    tick();
    instr_in = 15'h0456;
    tick();
    instr_valid = 1'b0;
    tick();
    chk("flush_pre_busy", 32'(busy3), 32'd1);
    chk("flush_pre_valid", 32'(rv3), 32'd0);
    flush = 1'b1;
    #1;
    chk("flush_instr_ready", 32'(ir3), 32'd0);
    tick();
    flush = 1'b0;
    chk("flush_count", 32'(cnt3), 32'd0);
    chk("flush_busy", 32'(busy3), 32'd0);
    chk("flush_ops_kept", 32'(ops3), 32'h0123);
    for (int c = 0; c < 4; c++) begin
      chk("flush_no_valid", 32'(rv3), 32'd0);
      tick();
    end
    g = 15'h0ABC;
    instr_in = g; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    chk("post_flush_ops", 32'(ops3), 32'(g));
    tick();
    tick();
    chk("post_flush_e3_valid", 32'(rv3), 32'd0);
    tick();
    chk("post_flush_e4_valid", 32'(rv3), 32'd1);
    chk("post_flush_k", 32'(rk3), 32'(kf(g)));
    chk("post_flush_cc", 32'(rcc3), 32'(ccf(g)));
    $display("post-flush issue: instr=%h res_k=%h res_cc=%h", g, rk3, rcc3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
